// File: rtl/discriminant_pkg.sv
// Shared widths and mode constants for the ray/sphere discriminant pipeline.
package discriminant_pkg;

  localparam int FRONT_ANY = 0;  // hit = Disc >= 0
  localparam int FRONT_REQ = 1;  // hit also needs sphere ahead of ray
  localparam int STAGES    = 5;

  function automatic int bw(input int w);
    return 2*w + 4;
  endfunction

  function automatic int dw(input int w);
    return 4*w + 9;
  endfunction

endpackage

// File: rtl/discriminant_pipe_dot3.sv
// Two-stage registered 3-term signed dot product minus an optional bias term.
module dot3_signed #(
  parameter int IW = 17,
  parameter int OW = 36
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic [2:0][IW-1:0]   i_a,
  input  logic [2:0][IW-1:0]   i_b,
  input  logic [2*IW-1:0]      i_sub,
  output logic [OW-1:0]        o_sum
);

  localparam int PW = 2*IW;

  logic [2:0][PW-1:0] w_a_ext;
  logic [2:0][PW-1:0] w_b_ext;
  logic [2:0][PW-1:0] r_prod;
  logic [PW-1:0]      r_sub;
  logic [3:0][OW-1:0] w_term;
  logic [OW-1:0]      r_sum;

  // Sign-extend to the product width so a plain multiply yields the exact signed product.
  for (genvar k = 0; k < 3; k++) begin : g_term
    assign w_a_ext[k] = {{IW{i_a[k][IW-1]}}, i_a[k]};
    assign w_b_ext[k] = {{IW{i_b[k][IW-1]}}, i_b[k]};
    assign w_term[k]  = {{(OW-PW){r_prod[k][PW-1]}}, r_prod[k]};
  end
  assign w_term[3] = {{(OW-PW){r_sub[PW-1]}}, r_sub};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prod <= '0;
      r_sub  <= '0;
      r_sum  <= '0;
    end else if (i_en) begin
      for (int k = 0; k < 3; k++) r_prod[k] <= w_a_ext[k] * w_b_ext[k];
      r_sub <= i_sub;
      r_sum <= w_term[0] + w_term[1] + w_term[2] - w_term[3];
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/discriminant_pipe.sv
// Five-stage ray/sphere discriminant engine with a global-stall valid/ready pipeline.
module discriminant_pipe
  import discriminant_pkg::*;
#(
  parameter  int W          = 16,
  parameter  int TAG_W      = 8,
  parameter  int FRONT_ONLY = FRONT_ANY,
  localparam int BW         = bw(W),
  localparam int DW         = dw(W)
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic signed [W-1:0]  SphereX,
  input  logic signed [W-1:0]  SphereY,
  input  logic signed [W-1:0]  SphereZ,
  input  logic signed [W-1:0]  SphereRadius,
  input  logic signed [W-1:0]  RayStartX,
  input  logic signed [W-1:0]  RayStartY,
  input  logic signed [W-1:0]  RayStartZ,
  input  logic signed [W-1:0]  RayDirX,
  input  logic signed [W-1:0]  RayDirY,
  input  logic signed [W-1:0]  RayDirZ,
  input  logic [TAG_W-1:0]     TagIn,
  input  logic                 InputValid,
  output logic                 InputReady,
  output logic                 OutputValid,
  input  logic                 OutputReady,
  output logic                 Hit,
  output logic signed [DW-1:0] Discriminant,
  output logic signed [BW-1:0] B_out,
  output logic [TAG_W-1:0]     TagOut,
  output logic [2:0]           InFlight
);

  localparam int IW = W + 1;

  logic                      w_adv;
  logic                      w_acc;
  logic                      w_cons;
  logic [STAGES:1]           r_vld_pipe;
  logic [4:1][TAG_W-1:0]     r_tag;

  logic [2:0][W-1:0]         w_o;
  logic [2:0][W-1:0]         w_c;
  logic [2:0][W-1:0]         w_d;
  logic [2:0][IW-1:0]        r_oc;
  logic [2:0][IW-1:0]        r_d;
  logic [W-1:0]              r_r;
  logic [2*IW-1:0]           w_r_ext;
  logic [2*IW-1:0]           w_rr;

  logic [2:0][2:0][IW-1:0]   w_dot_a;
  logic [2:0][2:0][IW-1:0]   w_dot_b;
  logic [2:0][2*IW-1:0]      w_dot_sub;
  logic [2:0][BW-1:0]        w_dot_sum;
  logic [BW-1:0]             w_b;
  logic [BW-1:0]             w_a;
  logic [BW-1:0]             w_cc;
  logic [2*BW-1:0]           w_b_ext;
  logic [2*BW-1:0]           w_a_ext;
  logic [2*BW-1:0]           w_cc_ext;

  logic [2*BW-1:0]           r_bb;
  logic [2*BW-1:0]           r_ac;
  logic [BW-1:0]             r_b4;
  logic                      r_front4;
  logic [DW-1:0]             w_disc;
  logic                      w_hit;

  logic                      r_hit;
  logic [DW-1:0]             r_disc;
  logic [BW-1:0]             r_bout;
  logic [TAG_W-1:0]          r_tagout;
  logic [2:0]                r_inflight;

  // Global stall: every stage moves together, so ready never looks at InputValid.
  assign w_adv       = !OutputValid || OutputReady;
  assign InputReady  = w_adv;
  assign OutputValid = r_vld_pipe[STAGES];
  assign w_acc       = InputValid && w_adv;
  assign w_cons      = OutputValid && OutputReady;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_inflight <= '0;
    end else begin
      if (w_adv) r_vld_pipe <= {r_vld_pipe[STAGES-1:1], InputValid};
      r_inflight <= r_inflight + {2'b0, w_acc} - {2'b0, w_cons};
    end
  end

  assign w_o = {RayStartZ, RayStartY, RayStartX};
  assign w_c = {SphereZ, SphereY, SphereX};
  assign w_d = {RayDirZ, RayDirY, RayDirX};

  // S1: origin-to-centre offset, one extra bit so O-C never wraps.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_oc  <= '0;
      r_d   <= '0;
      r_r   <= '0;
      r_tag <= '0;
    end else if (w_adv) begin
      for (int i = 0; i < 3; i++) begin
        r_oc[i] <= {w_o[i][W-1], w_o[i]} - {w_c[i][W-1], w_c[i]};
        r_d[i]  <= {w_d[i][W-1], w_d[i]};
      end
      r_r   <= SphereRadius;
      r_tag <= {r_tag[3:1], TagIn};
    end
  end

  assign w_r_ext = {{(W+2){r_r[W-1]}}, r_r};
  assign w_rr    = w_r_ext * w_r_ext;

  // S2+S3: lane 0 = D.oc (B), lane 1 = D.D (A), lane 2 = oc.oc - r*r (Cc).
  assign w_dot_a   = {r_oc, r_d, r_d};
  assign w_dot_b   = {r_oc, r_d, r_oc};
  assign w_dot_sub = {w_rr, {(2*IW){1'b0}}, {(2*IW){1'b0}}};

  for (genvar k = 0; k < 3; k++) begin : g_dot
    dot3_signed #(.IW(IW), .OW(BW)) u_dot (
      .i_clk   (CLK),
      .i_reset (reset),
      .i_en    (w_adv),
      .i_a     (w_dot_a[k]),
      .i_b     (w_dot_b[k]),
      .i_sub   (w_dot_sub[k]),
      .o_sum   (w_dot_sum[k])
    );
  end

  assign w_b      = w_dot_sum[0];
  assign w_a      = w_dot_sum[1];
  assign w_cc     = w_dot_sum[2];
  assign w_b_ext  = {{BW{w_b[BW-1]}}, w_b};
  assign w_a_ext  = {{BW{w_a[BW-1]}}, w_a};
  assign w_cc_ext = {{BW{w_cc[BW-1]}}, w_cc};

  // S4: full-precision squares; front-facing test is resolved here so Cc need not travel on.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_bb     <= '0;
      r_ac     <= '0;
      r_b4     <= '0;
      r_front4 <= 1'b0;
    end else if (w_adv) begin
      r_bb     <= w_b_ext * w_b_ext;
      r_ac     <= w_a_ext * w_cc_ext;
      r_b4     <= w_b;
      r_front4 <= w_b[BW-1] || w_cc[BW-1] || (w_cc == '0);
    end
  end

  assign w_disc = {r_bb[2*BW-1], r_bb} - {r_ac[2*BW-1], r_ac};
  assign w_hit  = !w_disc[DW-1] && ((FRONT_ONLY == FRONT_ANY) || r_front4);

  // S5: result registers hold while stalled.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_hit    <= 1'b0;
      r_disc   <= '0;
      r_bout   <= '0;
      r_tagout <= '0;
    end else if (w_adv) begin
      r_hit    <= w_hit;
      r_disc   <= w_disc;
      r_bout   <= r_b4;
      r_tagout <= r_tag[4];
    end
  end

  assign Hit          = r_hit;
  assign Discriminant = r_disc;
  assign B_out        = r_bout;
  assign TagOut       = r_tagout;
  assign InFlight     = r_inflight;

endmodule

// File: doc/discriminant_pipe.md
Name: discriminant_pipe

Overview:
- Fully pipelined, parametrised ray–sphere discriminant engine; successor to the single-shot DiscriminantCalculator.
- Accepts one ray/sphere pair per cycle at full throughput and returns:
  - half-b: B = D·(O−C)
  - quarter-discriminant: Disc = B² − A·Cc, where A = D·D and Cc = |O−C|² − r²
  - hit flag and an opaque tag
- Sits between the ray/sphere dispatcher and the nearest-hit/root stage.
- Valid/ready handshake with full backpressure on both sides.

Parameters:
- W, 16: signed width of every coordinate, direction and radius input.
- TAG_W, 8: width of the passthrough tag (ray/sphere ID).
- FRONT_ONLY, 0: 1 = hit also requires the sphere to be ahead of the ray (B<0 or Cc≤0); 0 = hit is Disc≥0 only.
- BW, 2*W+4 (localparam): signed width of B, A and Cc.
- DW, 4*W+9 (localparam): signed width of Disc.

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high reset
- SphereX/SphereY/SphereZ  in  W each  sphere centre, signed
- SphereRadius  in  W  radius, signed, treated as magnitude by squaring
- RayStartX/RayStartY/RayStartZ  in  W each  ray origin, signed
- RayDirX/RayDirY/RayDirZ  in  W each  ray direction, signed, unnormalised
- TagIn  in  TAG_W  carried unchanged to TagOut
- InputValid  in  1  input pair present
- InputReady  out  1  pipeline can accept this cycle
- OutputValid  out  1  result present
- OutputReady  in  1  downstream accepts result
- Hit  out  1  intersection flag
- Discriminant  out  DW  B² − A·Cc, signed
- B_out  out  BW  half-b, signed
- TagOut  out  TAG_W  tag of the current result
- InFlight  out  3  count of valid entries in the pipeline, 0..5

Behaviour:
- Reset: all stage valid bits cleared; OutputValid=0, Hit=0, Discriminant=0, B_out=0, TagOut=0, InFlight=0. InputReady=1 in the first cycle after reset deasserts.
- Reset mid-operation drops every in-flight entry; no output is produced for them.
- Accept: transfer occurs when InputValid && InputReady at a rising CLK edge.
- Output: consumed when OutputValid && OutputReady.
- Pipeline stages (5 registered stages; latency 5 cycles from accept to OutputValid when unstalled):
  - S1: oc = O − C per axis, W+1 bits; register D, r.
  - S2: nine products D·oc, oc·oc, D·D per axis, plus r·r; each 2W+2 bits.
  - S3: B = ΣD·oc; A = ΣD·D; Cc = Σoc·oc − r·r; all BW bits.
  - S4: B·B and A·Cc, full precision.
  - S5: Disc = B·B − A·Cc (DW bits). Hit = (Disc≥0) && (!FRONT_ONLY || B<0 || Cc≤0). Register outputs.
- Arithmetic: all signed, full precision, no truncation, no saturation. Widths are sized so that no overflow is possible for any W-bit input.
- Flow control is a global stall: advance = !OutputValid || OutputReady.
  - All stages shift only when advance=1.
  - InputReady = advance (combinational from OutputValid/OutputReady only, never from InputValid).
  - While stalled, outputs hold stable; stalled bubbles are not compacted.
- Throughput: 1 result/cycle with OutputReady held at 1.
- Ordering: results emerge in acceptance order; TagOut always matches its own operands.
- InFlight: +1 on accept, −1 on output consume; a simultaneous accept and consume leaves it unchanged. Never exceeds 5.
- Degenerate cases:
  - D=0 gives A=0, B=0, Disc=0, so Hit=1 if FRONT_ONLY=0. This is intentional; the dispatcher filters zero directions.
  - Radius 0 is legal.
- Boundary: −2^(W−1) on every input must produce the mathematically exact result.

Decomposition:
- Shared package discriminant_pkg holds:
  - function bw(W) = 2*W+4 and dw(W) = 4*W+9
  - typedef of a vec3 struct parametrised by width, if the tool flow allows; otherwise three separate signals
  - FRONT_ONLY mode constants
- One natural sub-module: dot3_signed — a registered 3-term signed dot product (S2+S3), instantiated three times for D·oc, oc·oc and D·D.

Test Plan:
- Sphere r=2 at (0,0,0); ray from (0,10,0), dir (0,−1,0), tag 0x11 → after 5 cycles: B_out=−10, Discriminant=4, Hit=1, TagOut=0x11, InFlight returns to 0.
- Sphere r=2 at (10,−10,10); same ray → B_out=−20, Discriminant=−196, Hit=0.
- FRONT_ONLY=1; sphere r=2 at (0,−20,0) behind a ray from (0,10,0), dir (0,1,0) → B_out=30, Cc=896, Discriminant=4, Hit=0. With FRONT_ONLY=0 the same case gives Hit=1.
- Stream 8 back-to-back pairs, OutputReady=1 → 8 results on consecutive cycles, in order, tags 0..7; InputReady stays 1.
- Hold OutputReady=0 while streaming → InputReady drops once OutputValid=1, InFlight stalls at 5 max, outputs stable. Release → all remaining results drain in order with no loss or duplication.
- Assert reset with 3 entries in flight → next cycle OutputValid=0, InFlight=0, all outputs 0; no stale result emerges afterwards.
- All-inputs −32768 (W=16) → exact B/Disc match the reference model, no overflow.
